// File: rtl/v20_pkg.sv
// rtl/v20_pkg.sv - shared V20 bus-cycle state encoding and status bit layout
package v20_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_TW   = 3'd4,
        ST_T4   = 3'd5
    } v20_state_e;

    // Status vector layout for the minimum-mode IO/M, DT/R and SSO pins.
    localparam int STS_W   = 3;
    localparam int STS_SSO = 0;
    localparam int STS_DTR = 1;
    localparam int STS_IOM = 2;

    localparam logic [STS_W-1:0] STS_RESET = STS_W'(1) << STS_SSO;

    localparam int WAIT_W = 8;

    function automatic logic [STS_W-1:0] v20_status(input logic io, input logic wr);
        logic [STS_W-1:0] s;
        s          = '0;
        s[STS_IOM] = io;
        s[STS_DTR] = wr;
        s[STS_SSO] = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/v20_tstate_gen.sv
// rtl/v20_tstate_gen.sv - free-running T-state phase counter, V20 clock and phase strobes
module v20_tstate_gen #(
    parameter int T_CLKS = 2
) (
    input  logic iClk,
    input  logic iRst,
    output logic oV20Clk,
    output logic oLast,
    output logic oNextLast
);

    localparam int PW = (T_CLKS > 1) ? $clog2(T_CLKS) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(T_CLKS - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(T_CLKS / 2);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;
    logic          clk_q;

    assign phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);

    // clk_q is computed from phase_d so it lines up with the registered phase.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            phase_q <= '0;
            clk_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            clk_q   <= (phase_d < PH_HALF);
        end
    end

    assign oV20Clk   = clk_q;
    assign oLast     = (phase_q == PH_LAST);
    assign oNextLast = (phase_d == PH_LAST);

endmodule

// File: rtl/v20_bus_master.sv
// rtl/v20_bus_master.sv - request/response front end driving V20 minimum-mode bus cycles
module v20_bus_master
    import v20_pkg::*;
#(
    parameter int T_CLKS     = 2,  // must be >= 2
    parameter int WAIT_LIMIT = 255
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic        iReqWr,
    input  logic        iReqIo,
    input  logic [19:0] iReqAddr,
    input  logic [7:0]  iReqData,
    output logic        oRspValid,
    output logic [7:0]  oRspData,
    output logic        oRspErr,
    input  logic        iV20Ready,
    output logic        oV20Clk,
    output logic [11:0] oV20Addr,
    output logic [7:0]  oV20Data,
    input  logic [7:0]  iV20Data,
    output logic        oV20Oe,
    output logic        oV20Ale,
    output logic        oV20Iom,
    output logic        oV20Dtr,
    output logic        oV20Sso,
    output logic        oV20RdN,
    output logic        oV20WrN
);

    logic t_last;
    logic t_next_last;

    v20_tstate_gen #(
        .T_CLKS(T_CLKS)
    ) u_tstate (
        .iClk      (iClk),
        .iRst      (iRst),
        .oV20Clk   (oV20Clk),
        .oLast     (t_last),
        .oNextLast (t_next_last)
    );

    v20_state_e         state_q;
    logic               pend_q;
    logic               ready_q;
    logic               wr_q;
    logic               io_q;
    logic [19:0]        addr_q;
    logic [7:0]         wdata_q;
    logic [WAIT_W-1:0]  wait_q;
    logic               err_q;
    logic [7:0]         cap_q;
    logic               rsp_valid_q;
    logic [7:0]         rsp_data_q;
    logic               rsp_err_q;
    logic               ale_q;
    logic               oe_q;
    logic               rdn_q;
    logic               wrn_q;
    logic [11:0]        ah_q;
    logic [7:0]         ad_q;
    logic [STS_W-1:0]   sts_q;

    logic        acc;
    logic [19:0] in_addr;
    logic [19:0] sel_addr;
    logic        sel_wr;
    logic        sel_io;
    logic        wait_lim_hit;

    // An accept on the last phase goes straight to T1, so the live request fields are muxed in.
    assign acc          = ready_q & iReqValid;
    assign in_addr      = iReqIo ? {4'h0, iReqAddr[15:0]} : iReqAddr;
    assign sel_addr     = acc ? in_addr : addr_q;
    assign sel_wr       = acc ? iReqWr : wr_q;
    assign sel_io       = acc ? iReqIo : io_q;
    assign wait_lim_hit = (32'(wait_q) >= 32'(WAIT_LIMIT));

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            ready_q     <= 1'b0;
            wr_q        <= 1'b0;
            io_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_q      <= '0;
            err_q       <= 1'b0;
            cap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            ale_q       <= 1'b0;
            oe_q        <= 1'b0;
            rdn_q       <= 1'b1;
            wrn_q       <= 1'b1;
            ah_q        <= '0;
            ad_q        <= '0;
            sts_q       <= STS_RESET;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        wr_q    <= iReqWr;
                        io_q    <= iReqIo;
                        addr_q  <= in_addr;
                        wdata_q <= iReqData;
                        ready_q <= 1'b0;
                    end
                    if ((acc || pend_q) && t_last) begin
                        state_q <= ST_T1;
                        pend_q  <= 1'b0;
                        ready_q <= 1'b0;
                        wait_q  <= '0;
                        err_q   <= 1'b0;
                        ale_q   <= 1'b1;
                        oe_q    <= 1'b1;
                        ah_q    <= sel_addr[19:8];
                        ad_q    <= sel_addr[7:0];
                        sts_q   <= v20_status(sel_io, sel_wr);
                    end else if (acc) begin
                        pend_q <= 1'b1;
                    end else if (!pend_q) begin
                        ready_q <= 1'b1;
                    end
                end
                ST_T1: begin
                    if (t_last) begin
                        state_q <= ST_T2;
                        ale_q   <= 1'b0;
                        if (wr_q) begin
                            ad_q  <= wdata_q;
                            wrn_q <= 1'b0;
                        end else begin
                            oe_q  <= 1'b0;
                            rdn_q <= 1'b0;
                        end
                    end
                end
                ST_T2: begin
                    if (t_last) begin
                        state_q <= ST_T3;
                    end
                end
                ST_T3, ST_TW: begin
                    // A low READY that would push the wait count past the limit aborts into T4.
                    if (t_last) begin
                        if (iV20Ready || wait_lim_hit) begin
                            state_q <= ST_T4;
                            cap_q   <= iV20Data;
                            err_q   <= ~iV20Ready;
                            rdn_q   <= 1'b1;
                            wrn_q   <= 1'b1;
                            oe_q    <= 1'b0;
                        end else begin
                            state_q <= ST_TW;
                            wait_q  <= (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
                        end
                    end
                end
                ST_T4: begin
                    if (t_next_last) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rsp_data_q  <= wr_q ? 8'h00 : cap_q;
                    end
                    if (t_last) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign oReqReady = ready_q;
    assign oRspValid = rsp_valid_q;
    assign oRspData  = rsp_data_q;
    assign oRspErr   = rsp_err_q;
    assign oV20Addr  = ah_q;
    assign oV20Data  = ad_q;
    assign oV20Oe    = oe_q;
    assign oV20Ale   = ale_q;
    assign oV20Iom   = sts_q[STS_IOM];
    assign oV20Dtr   = sts_q[STS_DTR];
    assign oV20Sso   = sts_q[STS_SSO];
    assign oV20RdN   = rdn_q;
    assign oV20WrN   = wrn_q;

endmodule

// File: tb/tb_v20_bus_master.sv
// tb/tb_v20_bus_master.sv - directed scoreboard bench for v20_bus_master
module tb_v20_bus_master;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iReqValid;
    logic        oReqReady;
    logic        iReqWr;
    logic        iReqIo;
    logic [19:0] iReqAddr;
    logic [7:0]  iReqData;
    logic        oRspValid;
    logic [7:0]  oRspData;
    logic        oRspErr;
    logic        iV20Ready;
    logic        oV20Clk;
    logic [11:0] oV20Addr;
    logic [7:0]  oV20Data;
    logic [7:0]  iV20Data;
    logic        oV20Oe;
    logic        oV20Ale;
    logic        oV20Iom;
    logic        oV20Dtr;
    logic        oV20Sso;
    logic        oV20RdN;
    logic        oV20WrN;

    always #5 iClk = ~iClk;

    v20_bus_master #(
        .T_CLKS     (2),
        .WAIT_LIMIT (255)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iReqValid (iReqValid),
        .oReqReady (oReqReady),
        .iReqWr    (iReqWr),
        .iReqIo    (iReqIo),
        .iReqAddr  (iReqAddr),
        .iReqData  (iReqData),
        .oRspValid (oRspValid),
        .oRspData  (oRspData),
        .oRspErr   (oRspErr),
        .iV20Ready (iV20Ready),
        .oV20Clk   (oV20Clk),
        .oV20Addr  (oV20Addr),
        .oV20Data  (oV20Data),
        .iV20Data  (iV20Data),
        .oV20Oe    (oV20Oe),
        .oV20Ale   (oV20Ale),
        .oV20Iom   (oV20Iom),
        .oV20Dtr   (oV20Dtr),
        .oV20Sso   (oV20Sso),
        .oV20RdN   (oV20RdN),
        .oV20WrN   (oV20WrN)
    );

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t mon_e;
    int   mon_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge iClk) cyc <= cyc + 1;

    // Scoreboard and bus-protocol monitor, sampled mid-cycle.
    always @(negedge iClk) begin
        chk("rd_wr_both_low", 32'(!oV20RdN && !oV20WrN), 0);
        chk("oe_with_rd_low", 32'(oV20Oe && !oV20RdN), 0);
        if (!iRst && iReqValid && oReqReady) acc_q.push_back(cyc);
        if (oRspValid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                chk("rsp_data", oRspData, mon_e.data);
                chk("rsp_err", oRspErr, mon_e.err);
                chk("rsp_latency", cyc - mon_a, mon_e.lat);
            end
        end
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Ends on a cycle in the last T-state phase with the request port open.
    task automatic align();
        int n = 0;
        while (!(oReqReady && !oV20Clk) && n < 20) begin
            step();
            n++;
        end
        chk("align", 32'(oReqReady && !oV20Clk), 1);
    endtask

    task automatic send(input logic wr, input logic io, input logic [19:0] addr, input logic [7:0] data);
        iReqValid = 1'b1;
        iReqWr    = wr;
        iReqIo    = io;
        iReqAddr  = addr;
        iReqData  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int idle;
        iRst      = 1'b1;
        iReqValid = 1'b0;
        iReqWr    = 1'b0;
        iReqIo    = 1'b0;
        iReqAddr  = '0;
        iReqData  = '0;
        iV20Ready = 1'b1;
        iV20Data  = '0;
        step();
        step();

        // Reset values
        chk("rst_ready", oReqReady, 0);
        chk("rst_rsp", {oRspValid, oRspErr, oRspData}, 0);
        chk("rst_strobes", {oV20Ale, oV20Oe, oV20RdN, oV20WrN}, 4'b0011);
        chk("rst_status", {oV20Iom, oV20Dtr, oV20Sso}, 3'b001);
        chk("rst_bus", {oV20Addr, oV20Data}, 0);
        chk("rst_clk", oV20Clk, 0);
        iRst = 1'b0;
        step();
        chk("ready_after_rst", oReqReady, 1);

        // Memory read at 0xF0123, zero wait
        align();
        iV20Data  = 8'h5A;
        iV20Ready = 1'b1;
        send(1'b0, 1'b0, 20'hF0123, 8'h00);
        exp_q.push_back('{data: 8'h5A, err: 1'b0, lat: 8});
        step();
        iReqValid = 1'b0;
        chk("rd_t1_ale", oV20Ale, 1);
        chk("rd_t1_ah", oV20Addr, 12'hF01);
        chk("rd_t1_ad", oV20Data, 8'h23);
        chk("rd_t1_oe", oV20Oe, 1);
        chk("rd_t1_iom_dtr", {oV20Iom, oV20Dtr}, 2'b00);
        step();
        step();
        chk("rd_t2_ale", oV20Ale, 0);
        chk("rd_t2_rdn", oV20RdN, 0);
        chk("rd_t2_oe", oV20Oe, 0);
        step();
        step();
        step();
        chk("rd_t3_rdn", oV20RdN, 0);
        step();
        chk("rd_t4_rdn", oV20RdN, 1);
        step();
        chk("rd_rsp_pulse", oRspValid, 1);
        step();
        chk("rd_rsp_single", oRspValid, 0);
        chk("rd_rsp_hold", oRspData, 8'h5A);

        // I/O write of 0xA5 to port 0x03D4
        align();
        send(1'b1, 1'b1, 20'h003D4, 8'hA5);
        exp_q.push_back('{data: 8'h00, err: 1'b0, lat: 8});
        step();
        iReqValid = 1'b0;
        chk("wr_t1_ah", oV20Addr, 12'h003);
        chk("wr_t1_ad", oV20Data, 8'hD4);
        chk("wr_t1_iom_dtr", {oV20Iom, oV20Dtr}, 2'b11);
        step();
        step();
        chk("wr_t2_ad", oV20Data, 8'hA5);
        chk("wr_t2_oe_wrn_rdn", {oV20Oe, oV20WrN, oV20RdN}, 3'b101);
        step();
        step();
        step();
        chk("wr_t3_wrn", oV20WrN, 0);
        step();
        chk("wr_t4_release", {oV20WrN, oV20Oe}, 2'b10);
        chk("wr_t4_iom_dtr", {oV20Iom, oV20Dtr}, 2'b11);
        step();
        step();

        // Read with READY low during T3, TW1 and TW2
        align();
        iV20Ready = 1'b0;
        iV20Data  = 8'h11;
        send(1'b0, 1'b0, 20'h12345, 8'h00);
        exp_q.push_back('{data: 8'h3C, err: 1'b0, lat: 14});
        for (int s = 1; s <= 15; s++) begin
            step();
            if (s == 1) iReqValid = 1'b0;
            if (s == 11) begin
                iV20Ready = 1'b1;
                iV20Data  = 8'h3C;
            end
            if (s == 12) chk("tw_last_rdn", oV20RdN, 0);
            if (s == 13) chk("tw_t4_rdn", oV20RdN, 1);
        end

        // READY stuck low: abort after 255 wait states
        align();
        iV20Ready = 1'b0;
        iV20Data  = 8'h77;
        send(1'b0, 1'b0, 20'h00042, 8'h00);
        exp_q.push_back('{data: 8'h77, err: 1'b1, lat: 518});
        for (int s = 1; s <= 520; s++) begin
            step();
            if (s == 1) iReqValid = 1'b0;
            if (s == 516) chk("abort_tw_rdn", oV20RdN, 0);
            if (s == 517) chk("abort_t4_release", {oV20RdN, oV20Oe}, 2'b10);
        end
        iV20Ready = 1'b1;

        // Reset during T2 of a write abandons the cycle
        align();
        send(1'b1, 1'b0, 20'h00100, 8'hC3);
        step();
        iReqValid = 1'b0;
        step();
        step();
        chk("rst_t2_wrn", oV20WrN, 0);
        iRst = 1'b1;
        step();
        chk("rst_mid_release", {oV20WrN, oV20Oe}, 2'b10);
        chk("rst_mid_ready", oReqReady, 0);
        chk("rst_mid_rsp", oRspValid, 0);
        step();
        iRst = 1'b0;
        acc_q.delete();
        step();
        chk("rst_mid_ready_back", oReqReady, 1);
        for (int s = 0; s < 12; s++) step();

        // Back-to-back reads: second request held valid while the first runs
        align();
        iV20Data  = 8'h81;
        iV20Ready = 1'b1;
        send(1'b0, 1'b0, 20'h40000, 8'h00);
        exp_q.push_back('{data: 8'h81, err: 1'b0, lat: 8});
        exp_q.push_back('{data: 8'h42, err: 1'b0, lat: 9});
        step();
        iReqAddr = 20'h50001;
        n = 0;
        while (!oRspValid && n < 20) begin
            step();
            n++;
        end
        chk("b2b_first_rsp", oRspValid, 1);
        iV20Data = 8'h42;
        step();
        chk("b2b_ready", oReqReady, 1);
        idle = 1;
        step();
        iReqValid = 1'b0;
        while (!oV20Ale && idle < 10) begin
            idle++;
            step();
        end
        // One IDLE T-state (T_CLKS iClk cycles) separates the two bus cycles.
        chk("b2b_idle_cycles", idle, 2);
        chk("b2b_second_ah", oV20Addr, 12'h500);
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            step();
            n++;
        end
        step();
        chk("sb_empty", exp_q.size(), 0);
        chk("acc_empty", acc_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
